// File: rtl/pulse_delay.sv
// Delays each rising edge of a trigger by a fixed number of clock cycles, with a
// selectable policy for triggers that arrive while a delay is already running.

module pulse_delay_timer #(
   parameter int CW = 1,
   parameter int N  = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic active,
   output logic expiring
);

   localparam logic [CW-1:0] N_V = CW'(N);

   logic [CW-1:0] cnt_q, cnt_d;

   // A load on the expiry edge simply restarts the count; no wrap is possible.
   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = N_V;
      else if (cnt_q != '0)
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign active   = (cnt_q != '0);
   assign expiring = (cnt_q == CW'(1));

endmodule

module pulse_delay #(
   parameter int CLK_NS   = 20,
   parameter int DELAY_NS = 1000,
   parameter int MAXPEND  = 4,
   parameter int MODE     = 0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in,
   output logic                         out,
   output logic                         lv,
   output logic [$clog2(MAXPEND+1)-1:0] pend,
   output logic                         drop
);

   localparam int N  = (DELAY_NS + CLK_NS - 1) / CLK_NS;
   localparam int CW = (N < 1) ? 1 : $clog2(N + 1);
   localparam int NT = (MODE == 2 && MAXPEND >= 1) ? MAXPEND : 1;
   localparam int PW = (MAXPEND < 1) ? 1 : $clog2(MAXPEND + 1);

   if (N < 1 || MAXPEND < 1 || MODE < 0 || MODE > 2) begin : g_param_err
      $error("pulse_delay: illegal parameters (N=%0d MAXPEND=%0d MODE=%0d)", N, MAXPEND, MODE);
   end

   logic          in_d_q, in_d_d;
   logic          out_q, out_d;
   logic          drop_q, drop_d;
   logic          trig;
   logic          found;
   logic [NT-1:0] act, expr, free, load;
   logic [PW-1:0] pend_d;

   // An expiring timer counts as free so a trigger on its expiry edge is taken;
   // in retrigger mode the single timer is always reloadable.
   for (genvar i = 0; i < NT; i++) begin : g_tmr
      pulse_delay_timer #(.CW(CW), .N(N)) u_tmr (
         .clk      (clk),
         .reset    (reset),
         .load     (load[i]),
         .active   (act[i]),
         .expiring (expr[i])
      );
      assign free[i] = (MODE == 1) || !act[i] || expr[i];
   end

   always_comb begin
      in_d_d = in;
      trig   = in & ~in_d_q;
      load   = '0;
      found  = 1'b0;
      for (int i = 0; i < NT; i++) begin
         if (trig && free[i] && !found) begin
            load[i] = 1'b1;
            found   = 1'b1;
         end
      end
      drop_d = trig & ~found;
      out_d  = |expr;
      pend_d = '0;
      for (int i = 0; i < NT; i++)
         pend_d = pend_d + PW'(act[i]);
   end

   // in_d resets high so a level held through reset release is not a trigger.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_d_q <= 1'b1;
         out_q  <= 1'b0;
         drop_q <= 1'b0;
      end else begin
         in_d_q <= in_d_d;
         out_q  <= out_d;
         drop_q <= drop_d;
      end
   end

   assign out  = out_q;
   assign drop = drop_q;
   assign lv   = |act;
   assign pend = pend_d;

endmodule

// File: tb/tb_pulse_delay.sv
// Drives one trigger/reset stream into six differently configured pulse_delay
// instances and compares every output each cycle against a deadline-list model.

module tb_pulse_delay;

   localparam int NC = 6;

   logic       clk, rst_r, in_r;
   logic       o_w [NC];
   logic       l_w [NC];
   logic       d_w [NC];
   logic [2:0] p_w [NC];
   logic [2:0] p0, p1, p2, p4;
   logic       p3;
   logic [1:0] p5;

   int checks, errors;
   int e;
   int m_prev;
   int mc     [NC];
   int m_out  [NC];
   int m_drop [NC];
   int dl     [NC][4];

   pulse_delay #(.MODE(0)) u0 (.clk(clk), .reset(rst_r), .in(in_r), .out(o_w[0]), .lv(l_w[0]), .pend(p0), .drop(d_w[0]));
   pulse_delay #(.MODE(1)) u1 (.clk(clk), .reset(rst_r), .in(in_r), .out(o_w[1]), .lv(l_w[1]), .pend(p1), .drop(d_w[1]));
   pulse_delay #(.MODE(2), .MAXPEND(4)) u2 (.clk(clk), .reset(rst_r), .in(in_r), .out(o_w[2]), .lv(l_w[2]), .pend(p2), .drop(d_w[2]));
   pulse_delay #(.MODE(2), .MAXPEND(1)) u3 (.clk(clk), .reset(rst_r), .in(in_r), .out(o_w[3]), .lv(l_w[3]), .pend(p3), .drop(d_w[3]));
   pulse_delay #(.MODE(0), .DELAY_NS(15)) u4 (.clk(clk), .reset(rst_r), .in(in_r), .out(o_w[4]), .lv(l_w[4]), .pend(p4), .drop(d_w[4]));
   pulse_delay #(.MODE(2), .MAXPEND(2), .DELAY_NS(61)) u5 (.clk(clk), .reset(rst_r), .in(in_r), .out(o_w[5]), .lv(l_w[5]), .pend(p5), .drop(d_w[5]));

   assign p_w[0] = p0;
   assign p_w[1] = p1;
   assign p_w[2] = p2;
   assign p_w[3] = {2'b00, p3};
   assign p_w[4] = p4;
   assign p_w[5] = {1'b0, p5};

   initial clk = 1'b0;
   always #10 clk = ~clk;

   function automatic int cm(int c);
      case (c)
         1:       return 1;
         2, 3, 5: return 2;
         default: return 0;
      endcase
   endfunction

   // Delay in cycles, ceil(DELAY_NS/CLK_NS): 1000/20=50, 15/20->1, 61/20->4.
   function automatic int cn(int c);
      case (c)
         4:       return 1;
         5:       return 4;
         default: return 50;
      endcase
   endfunction

   function automatic int cp(int c);
      case (c)
         3:       return 1;
         5:       return 2;
         default: return 4;
      endcase
   endfunction

   task automatic chk(string tag, int c, logic [31:0] obs, int exp);
      checks++;
      assert (obs === 32'(exp)) else begin
         errors++;
         $error("FAIL %s[u%0d] edge=%0d observed=%0d expected=%0d", tag, c, e, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int c = 0; c < NC; c++) begin
         chk("out",  c, 32'(o_w[c]), m_out[c]);
         chk("lv",   c, 32'(l_w[c]), (mc[c] > 0) ? 1 : 0);
         chk("pend", c, 32'(p_w[c]), mc[c]);
         chk("drop", c, 32'(d_w[c]), m_drop[c]);
      end
   endtask

   task automatic model_reset();
      m_prev = 1;
      for (int c = 0; c < NC; c++) begin
         mc[c] = 0; m_out[c] = 0; m_drop[c] = 0;
      end
   endtask

   // Each running delay is a deadline; expiry is retired before the new trigger is judged.
   task automatic model_edge();
      int trig;
      trig = (in_r && m_prev == 0 && !rst_r) ? 1 : 0;
      for (int c = 0; c < NC; c++) begin
         m_out[c] = 0; m_drop[c] = 0;
         if (rst_r) begin
            mc[c] = 0;
         end else begin
            if (mc[c] > 0 && dl[c][0] == e) begin
               m_out[c] = 1;
               for (int j = 0; j < 3; j++) dl[c][j] = dl[c][j+1];
               mc[c]--;
            end
            if (trig == 1) begin
               if (cm(c) == 1) begin
                  mc[c] = 1; dl[c][0] = e + cn(c);
               end else if ((cm(c) == 0 && mc[c] == 0) || (cm(c) == 2 && mc[c] < cp(c))) begin
                  dl[c][mc[c]] = e + cn(c); mc[c]++;
               end else begin
                  m_drop[c] = 1;
               end
            end
         end
      end
      m_prev = rst_r ? 1 : (in_r ? 1 : 0);
   endtask

   task automatic step();
      e++;
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic run(int n);
      repeat (n) step();
   endtask

   task automatic trig_pulse(int gap);
      in_r = 1'b1; step();
      in_r = 1'b0; run(gap);
   endtask

   task automatic async_reset(int hold);
      rst_r = 1'b1;
      #1;
      model_reset();
      check_all();
      run(hold);
      rst_r = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0; e = 0;
      in_r = 1'b0; rst_r = 1'b1;
      model_reset();
      #1;
      check_all();
      run(3);
      rst_r = 1'b0;
      run(5);

      // isolated pulse, then a second trigger 10 cycles in
      trig_pulse(60);
      trig_pulse(9);
      trig_pulse(60);
      // retrigger 30 cycles in
      trig_pulse(29);
      trig_pulse(90);
      // five triggers 4 cycles apart
      repeat (5) trig_pulse(3);
      run(70);
      // second trigger lands exactly on the 50-cycle expiry edge
      trig_pulse(49);
      trig_pulse(60);
      // reset 25 cycles into a delay with in held high across release
      trig_pulse(25);
      in_r = 1'b1;
      async_reset(3);
      run(5);
      in_r = 1'b0;
      run(60);

      // dense random triggers, then sparse, with occasional resets
      for (int k = 0; k < 3000; k++) begin
         if (k < 1500) in_r = ($urandom_range(0, 2) == 0);
         else          in_r = ($urandom_range(0, 60) == 0);
         if ($urandom_range(0, 599) == 0) async_reset($urandom_range(1, 3));
         else step();
      end
      in_r = 1'b0;
      run(60);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pulse_delay.md
PULSE_DELAY -- requirements
Module: pulse_delay

Interface
REQ-001 SHALL have parameter CLK_NS, default 20, clock period in ns.
REQ-002 SHALL have parameter DELAY_NS, default 1000, nominal delay in ns.
REQ-003 SHALL have parameter MAXPEND, default 4, maximum pulses in flight (MODE 2 only).
REQ-004 SHALL have parameter MODE, default 0, trigger policy: 0 = ignore while busy, 1 = retrigger (restart), 2 = queue (independent timers).
REQ-005 SHALL have port clk, input, 1, system clock.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have port in, input, 1, trigger; the rising edge is significant.
REQ-008 SHALL have port out, output, 1, one-cycle pulse at delay expiry.
REQ-009 SHALL have port lv, output, 1, level, high while any delay is running.
REQ-010 SHALL have port pend, output, $clog2(MAXPEND+1), count of delays running.
REQ-011 SHALL have port drop, output, 1, one-cycle pulse when a trigger is discarded.

Function
REQ-012 SHALL compute N = ceil(DELAY_NS/CLK_NS) at elaboration; N<1, MAXPEND<1 or MODE>2 SHALL be an elaboration error.
REQ-013 SHALL register in as in_d each edge; trigger at edge k iff in=1 and in_d=0 sampled at k; in held high for many cycles yields one trigger.
REQ-014 Latency: trigger accepted at edge k -> out high for exactly the one cycle after edge k+N.
REQ-015 lv SHALL be high after edges k..k+N-1 and low after edge k+N (lv and out non-overlapping for one isolated pulse).
REQ-016 pend SHALL equal the number of running timers; in MODE 0/1 it is 0 or 1.
REQ-017 MODE 0: a trigger while a timer runs SHALL be discarded, drop pulses one cycle, and the timer is unaffected.
REQ-018 MODE 1: a trigger while running SHALL restart the timer to a full N; drop stays 0; out fires once, N cycles after the last trigger.
REQ-019 MODE 2: each trigger SHALL start an independent timer; out fires N cycles after each accepted trigger, in order.
REQ-020 MODE 2: a trigger while pend=MAXPEND SHALL be discarded with a drop pulse; pend unchanged.
REQ-021 Simultaneous expiry and trigger at the same edge: the expiring timer SHALL be freed first, out pulses, and the trigger SHALL be accepted in all modes (no drop), with lv remaining high.
REQ-022 N=1: out SHALL pulse the cycle after the edge following the trigger, and lv SHALL be high for one cycle.
REQ-023 Because triggers are at least 2 cycles apart, at most one timer expires per edge; out SHALL never be high for two consecutive cycles unless expiries are on consecutive edges (impossible for N>=1).
REQ-024 Timer counters SHALL be $clog2(N+1) bits wide and SHALL not wrap.

Reset
REQ-025 reset high SHALL asynchronously force out=0, lv=0, pend=0, drop=0, clear all timers, and set in_d=1.
REQ-026 in held high through reset release SHALL NOT trigger; a low-then-high transition is required.
REQ-027 reset asserted mid-delay SHALL abort all pending pulses; no out pulse for them after release.

Verification (CLK_NS=20, DELAY_NS=1000 -> N=50 unless noted)
REQ-028 MODE 0: 20 ns pulse on in at t=110 ns -> out one cycle exactly 50 cycles after the accepting edge; lv high 50 cycles; pend 1 then 0.
REQ-029 MODE 0: second trigger 10 cycles after the first -> drop pulses once; single out at the original time.
REQ-030 MODE 1: triggers at edges k and k+30 -> single out after edge k+80; lv high continuously for 80 cycles.
REQ-031 MODE 2, MAXPEND=4: five triggers 4 cycles apart -> fifth drops; outs after edges k+50, k+54, k+58, k+62; pend peaks at 4.
REQ-032 MODE 2, MAXPEND=1: trigger exactly on the expiry edge -> out pulses, no drop, second out 50 cycles later.
REQ-033 Any mode: reset pulse 25 cycles into a delay -> all outputs 0 immediately, no out afterwards; in held high across release -> no trigger.
